// File: rtl/hw_accel_binary_bbox_pkg.sv
// Shared hw_accel constants: count-width derivation, foreground test, binary levels.
// Optional pixel count is enabled with HW_ACCEL_BBOX_PIXEL_COUNT_EN.
package hw_accel_binary_bbox_pkg;

    localparam logic [63:0] LEVEL_ZERO = 64'h0;
    localparam logic [63:0] LEVEL_ONE  = {64{1'b1}};

    function automatic int count_bits(input int n);
        return $clog2(n);
    endfunction

    function automatic logic is_fg(input logic [63:0] p);
        return p != LEVEL_ZERO;
    endfunction

endpackage

// File: rtl/hw_accel_binary_bbox_xy_counter.sv
// Valid-qualified raster x/y counter with wrap, sync clear and end-of-frame flag.
// Reusable by the dilation/erosion stages.
module hw_accel_xy_counter #(
    parameter int IMG_WIDTH   = 10,
    parameter int IMG_HEIGHT  = 4,
    parameter int X_COUNT_BIT = 4,
    parameter int Y_COUNT_BIT = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   advance,
    output logic [X_COUNT_BIT-1:0] x,
    output logic [Y_COUNT_BIT-1:0] y,
    output logic                   last
);

    localparam logic [X_COUNT_BIT-1:0] X_LAST = X_COUNT_BIT'(IMG_WIDTH - 1);
    localparam logic [Y_COUNT_BIT-1:0] Y_LAST = Y_COUNT_BIT'(IMG_HEIGHT - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x <= '0;
            y <= '0;
        end else if (clear) begin
            x <= '0;
            y <= '0;
        end else if (advance) begin
            if (x == X_LAST) begin
                x <= '0;
                y <= (y == Y_LAST) ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

    assign last = (x == X_LAST) && (y == Y_LAST);

endmodule

// File: rtl/hw_accel_binary_bbox.sv
// Binary bounding-box stage: forwards pixels and publishes per-frame foreground box.
// Define HW_ACCEL_BBOX_PIXEL_COUNT_EN to add the foreground pixel count output.
module hw_accel_binary_bbox
    import hw_accel_binary_bbox_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 10,
    parameter int IMG_HEIGHT = 4,
    localparam int X_COUNT_BIT = count_bits(IMG_WIDTH),
    localparam int Y_COUNT_BIT = count_bits(IMG_HEIGHT)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   frame_reset,
    input  logic [DATA_WIDTH-1:0]  pixel_in,
    input  logic                   pixel_in_valid,
    output logic [DATA_WIDTH-1:0]  pixel_out,
    output logic                   pixel_out_valid,
    output logic                   bbox_valid,
    output logic                   bbox_found,
    output logic [X_COUNT_BIT-1:0] bbox_x_min,
    output logic [X_COUNT_BIT-1:0] bbox_x_max,
    output logic [Y_COUNT_BIT-1:0] bbox_y_min,
    output logic [Y_COUNT_BIT-1:0] bbox_y_max
`ifdef HW_ACCEL_BBOX_PIXEL_COUNT_EN
    ,
    output logic [$clog2(IMG_WIDTH*IMG_HEIGHT+1)-1:0] bbox_pixel_count
`endif
);

    localparam logic [X_COUNT_BIT-1:0] X_EMPTY = X_COUNT_BIT'(IMG_WIDTH - 1);
    localparam logic [Y_COUNT_BIT-1:0] Y_EMPTY = Y_COUNT_BIT'(IMG_HEIGHT - 1);

    logic [X_COUNT_BIT-1:0] x_cnt;
    logic [Y_COUNT_BIT-1:0] y_cnt;
    logic                   at_last;
    logic                   take;

    logic [DATA_WIDTH-1:0]  pixel_r;
    logic                   valid_r;
    logic                   take_r;
    logic                   last_r;
    logic [X_COUNT_BIT-1:0] x_r;
    logic [Y_COUNT_BIT-1:0] y_r;

    logic                   eof;
    logic                   fg_hit;
    logic [X_COUNT_BIT-1:0] x_min_acc, x_max_acc;
    logic [Y_COUNT_BIT-1:0] y_min_acc, y_max_acc;
    logic                   found_acc;
    logic [X_COUNT_BIT-1:0] x_min_nxt, x_max_nxt;
    logic [Y_COUNT_BIT-1:0] y_min_nxt, y_max_nxt;
    logic                   found_nxt;

    // A pixel coinciding with frame_reset is forwarded but never accumulated.
    assign take = pixel_in_valid && !frame_reset;

    hw_accel_xy_counter #(
        .IMG_WIDTH  (IMG_WIDTH),
        .IMG_HEIGHT (IMG_HEIGHT),
        .X_COUNT_BIT(X_COUNT_BIT),
        .Y_COUNT_BIT(Y_COUNT_BIT)
    ) u_xy (
        .clk    (clk),
        .rst    (rst),
        .clear  (frame_reset),
        .advance(take),
        .x      (x_cnt),
        .y      (y_cnt),
        .last   (at_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pixel_r <= '0;
            valid_r <= 1'b0;
            take_r  <= 1'b0;
            last_r  <= 1'b0;
            x_r     <= '0;
            y_r     <= '0;
        end else begin
            pixel_r <= pixel_in;
            valid_r <= pixel_in_valid;
            take_r  <= take;
            last_r  <= take && at_last;
            x_r     <= frame_reset ? '0 : x_cnt;
            y_r     <= frame_reset ? '0 : y_cnt;
        end
    end

    assign pixel_out       = pixel_r;
    assign pixel_out_valid = valid_r;

    assign fg_hit = take_r && is_fg(64'(pixel_r));

    // On eof the accumulators restart from empty, merged with any new pixel.
    always_comb begin
        x_min_nxt = eof ? X_EMPTY : x_min_acc;
        x_max_nxt = eof ? '0      : x_max_acc;
        y_min_nxt = eof ? Y_EMPTY : y_min_acc;
        y_max_nxt = eof ? '0      : y_max_acc;
        found_nxt = eof ? 1'b0    : found_acc;
        if (fg_hit) begin
            if (x_r < x_min_nxt) x_min_nxt = x_r;
            if (x_r > x_max_nxt) x_max_nxt = x_r;
            if (y_r < y_min_nxt) y_min_nxt = y_r;
            if (y_r > y_max_nxt) y_max_nxt = y_r;
            found_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_min_acc <= X_EMPTY;
            x_max_acc <= '0;
            y_min_acc <= Y_EMPTY;
            y_max_acc <= '0;
            found_acc <= 1'b0;
            eof       <= 1'b0;
        end else if (frame_reset) begin
            x_min_acc <= X_EMPTY;
            x_max_acc <= '0;
            y_min_acc <= Y_EMPTY;
            y_max_acc <= '0;
            found_acc <= 1'b0;
            eof       <= 1'b0;
        end else begin
            x_min_acc <= x_min_nxt;
            x_max_acc <= x_max_nxt;
            y_min_acc <= y_min_nxt;
            y_max_acc <= y_max_nxt;
            found_acc <= found_nxt;
            eof       <= take_r && last_r;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bbox_valid <= 1'b0;
            bbox_found <= 1'b0;
            bbox_x_min <= '0;
            bbox_x_max <= '0;
            bbox_y_min <= '0;
            bbox_y_max <= '0;
        end else begin
            bbox_valid <= eof && !frame_reset;
            if (eof && !frame_reset) begin
                bbox_found <= found_acc;
                bbox_x_min <= found_acc ? x_min_acc : '0;
                bbox_x_max <= found_acc ? x_max_acc : '0;
                bbox_y_min <= found_acc ? y_min_acc : '0;
                bbox_y_max <= found_acc ? y_max_acc : '0;
            end
        end
    end

`ifdef HW_ACCEL_BBOX_PIXEL_COUNT_EN
    localparam int CNT_BIT = $clog2(IMG_WIDTH*IMG_HEIGHT+1);

    logic [CNT_BIT-1:0] cnt_acc;
    logic [CNT_BIT-1:0] cnt_base;

    assign cnt_base = eof ? '0 : cnt_acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_acc          <= '0;
            bbox_pixel_count <= '0;
        end else if (frame_reset) begin
            cnt_acc <= '0;
        end else begin
            if (fg_hit && cnt_base != '1)
                cnt_acc <= cnt_base + 1'b1;
            else
                cnt_acc <= cnt_base;
            if (eof)
                bbox_pixel_count <= cnt_acc;
        end
    end
`endif

endmodule

// File: tb/tb_hw_accel_binary_bbox.sv
// Self-checking bench for hw_accel_binary_bbox (10x4 frames), table-driven frames
// plus hand sequences for frame_reset and rst aborts.
module tb_hw_accel_binary_bbox;
    import hw_accel_binary_bbox_pkg::*;

    localparam int W = 10;
    localparam int H = 4;
    localparam int NV = 7;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_reset = 1'b0;
    logic [7:0] pixel_in = 8'h00;
    logic       pixel_in_valid = 1'b0;
    logic [7:0] pixel_out;
    logic       pixel_out_valid;
    logic       bbox_valid;
    logic       bbox_found;
    logic [3:0] bbox_x_min, bbox_x_max;
    logic [1:0] bbox_y_min, bbox_y_max;
`ifdef HW_ACCEL_BBOX_PIXEL_COUNT_EN
    logic [5:0] bbox_pixel_count;
`endif

    hw_accel_binary_bbox #(
        .DATA_WIDTH(8),
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .frame_reset    (frame_reset),
        .pixel_in       (pixel_in),
        .pixel_in_valid (pixel_in_valid),
        .pixel_out      (pixel_out),
        .pixel_out_valid(pixel_out_valid),
        .bbox_valid     (bbox_valid),
        .bbox_found     (bbox_found),
        .bbox_x_min     (bbox_x_min),
        .bbox_x_max     (bbox_x_max),
        .bbox_y_min     (bbox_y_min),
        .bbox_y_max     (bbox_y_max)
`ifdef HW_ACCEL_BBOX_PIXEL_COUNT_EN
        ,
        .bbox_pixel_count(bbox_pixel_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [39:0] mask;
        bit          gaps;
        logic        found;
        int          x0, x1, y0, y1;
        int          cnt;
    } vec_t;

    vec_t vt[NV];
    vec_t exp_q[$];
    vec_t last_exp;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_pix_cyc = 0;

    localparam logic [7:0] ONE = 8'(LEVEL_ONE);

    always @(posedge clk) cyc <= cyc + 1;

    function automatic vec_t mk(input logic [39:0] m, input bit g, input logic f,
                                input int x0, input int x1, input int y0,
                                input int y1, input int c);
        vec_t v;
        v.mask = m; v.gaps = g; v.found = f;
        v.x0 = x0; v.x1 = x1; v.y0 = y0; v.y1 = y1; v.cnt = c;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, req, cyc);
        end
    endtask

    task automatic send(input logic [7:0] p, input logic v, input logic fr);
        @(negedge clk);
        pixel_in       = p;
        pixel_in_valid = v;
        frame_reset    = fr;
    endtask

    task automatic send_pixels(input logic [39:0] mask, input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps)
                while ($urandom_range(0, 1) == 0) send(8'h5A, 1'b0, 1'b0);
            send(mask[i] ? ONE : 8'h00, 1'b1, 1'b0);
            if (i == 39) last_pix_cyc = cyc;
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
        check("pulse_arrived", exp_q.size(), 0);
    endtask

    // Output monitor: forwarding, pulse contents/latency/width, hold between pulses.
    initial begin
        logic [7:0] p;
        logic       pv, r;
        bit         prev_bv;
        vec_t       e;
        prev_bv  = 1'b0;
        last_exp = mk(40'd0, 1'b0, 1'b0, 0, 0, 0, 0, 0);
        forever begin
            @(posedge clk);
            p  = pixel_in;
            pv = pixel_in_valid;
            r  = rst;
            #1;
            if (r) begin
                last_exp = mk(40'd0, 1'b0, 1'b0, 0, 0, 0, 0, 0);
                check("rst_pixel_out_valid", int'(pixel_out_valid), 0);
                check("rst_bbox_valid", int'(bbox_valid), 0);
            end else begin
                check("pixel_out", int'(pixel_out), int'(p));
                check("pixel_out_valid", int'(pixel_out_valid), int'(pv));
                if (prev_bv) check("pulse_width", int'(bbox_valid), 0);
                if (bbox_valid) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_pulse", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        last_exp = e;
                        check("latency", cyc - last_pix_cyc, 3);
                    end
                end
                check("bbox_found", int'(bbox_found), int'(last_exp.found));
                check("bbox_x_min", int'(bbox_x_min), last_exp.x0);
                check("bbox_x_max", int'(bbox_x_max), last_exp.x1);
                check("bbox_y_min", int'(bbox_y_min), last_exp.y0);
                check("bbox_y_max", int'(bbox_y_max), last_exp.y1);
`ifdef HW_ACCEL_BBOX_PIXEL_COUNT_EN
                check("bbox_pixel_count", int'(bbox_pixel_count), last_exp.cnt);
`endif
            end
            prev_bv = bbox_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [39:0] m;
        vt[0] = mk(40'd1 << 23, 1'b0, 1'b1, 3, 3, 2, 2, 1);
        m = (40'd1 << 1) | (40'd1 << 18) | (40'd1 << 34);
        vt[1] = mk(m, 1'b0, 1'b1, 1, 8, 0, 3, 3);
        vt[2] = mk(40'd0, 1'b0, 1'b0, 0, 0, 0, 0, 0);
        vt[3] = mk(40'd1 << 39, 1'b0, 1'b1, 9, 9, 3, 3, 1);
        vt[4] = mk(40'd1, 1'b0, 1'b1, 0, 0, 0, 0, 1);
        vt[5] = mk(40'd1 << 15, 1'b0, 1'b1, 5, 5, 1, 1, 1);
        vt[6] = mk(m, 1'b1, 1'b1, 1, 8, 0, 3, 3);

        repeat (3) @(negedge clk);
        check("reset_bbox_valid", int'(bbox_valid), 0);
        check("reset_bbox_found", int'(bbox_found), 0);
        check("reset_x_min", int'(bbox_x_min), 0);
        check("reset_y_min", int'(bbox_y_min), 0);
        check("reset_pixel_out", int'(pixel_out), 0);
        rst = 1'b0;

        // Table frames streamed back to back, no idle between frames.
        for (int i = 0; i < NV; i++) begin
            exp_q.push_back(vt[i]);
            send_pixels(vt[i].mask, 40, vt[i].gaps);
        end
        send(8'h00, 1'b0, 1'b0);
        drain();

        // Abort with frame_reset after 15 pixels; the coinciding pixel is dropped.
        m = (40'd1 << 2) | (40'd1 << 12);
        send_pixels(m, 15, 1'b0);
        send(ONE, 1'b1, 1'b1);
        exp_q.push_back(mk(40'd1 << 27, 1'b0, 1'b1, 7, 7, 2, 2, 1));
        send_pixels(40'd1 << 27, 40, 1'b0);
        send(8'h00, 1'b0, 1'b0);
        drain();

        // Abort with rst after 15 pixels.
        send_pixels(m, 15, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        pixel_in_valid = 1'b0;
        #1;
        check("midrst_bbox_found", int'(bbox_found), 0);
        check("midrst_x_min", int'(bbox_x_min), 0);
        check("midrst_x_max", int'(bbox_x_max), 0);
        check("midrst_y_min", int'(bbox_y_min), 0);
        check("midrst_y_max", int'(bbox_y_max), 0);
        check("midrst_pixel_out_valid", int'(pixel_out_valid), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(mk(40'd1 << 27, 1'b0, 1'b1, 7, 7, 2, 2, 1));
        send_pixels(40'd1 << 27, 40, 1'b0);
        send(8'h00, 1'b0, 1'b0);
        drain();
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hw_accel_binary_bbox.md
Name: hw_accel_binary_bbox

Overview:
- Streaming stage directly downstream of hw_accel_binary_dilation; consumes its binary pixel stream (0 or all-ones).
- Tracks raster x/y position and accumulates the bounding box (min/max x, min/max y) of all foreground pixels in each frame.
- Publishes the box once per frame; the pixel stream is forwarded unchanged so further stages can chain.

Parameters:
- DATA_WIDTH, 8, pixel width.
- IMG_WIDTH, 10, pixels per line; must be >= 2.
- IMG_HEIGHT, 4, lines per frame; must be >= 2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- frame_reset  in  1  synchronous re-sync; clears position counters and accumulators.
- pixel_in  in  DATA_WIDTH  binary pixel; foreground = any nonzero value.
- pixel_in_valid  in  1  pixel_in qualifier; no backpressure.
- pixel_out  out  DATA_WIDTH  pixel_in delayed by 1 cycle.
- pixel_out_valid  out  1  pixel_in_valid delayed by 1 cycle.
- bbox_valid  out  1  single-cycle pulse; result of the completed frame.
- bbox_found  out  1  at least one foreground pixel in that frame.
- bbox_x_min, bbox_x_max  out  X_COUNT_BIT  box columns, inclusive.
- bbox_y_min, bbox_y_max  out  Y_COUNT_BIT  box rows, inclusive.

Behaviour:
- Reset (rst): all outputs 0; counters 0; accumulators at their empty values.
- Width: X_COUNT_BIT = $clog2(IMG_WIDTH); Y_COUNT_BIT = $clog2(IMG_HEIGHT).
- Stage 1:
  - Register pixel_in and pixel_in_valid; also provides the pixel_out path.
  - Capture the current x_count/y_count alongside.
  - Then advance the counters on each valid pixel: x wraps at IMG_WIDTH-1 and increments y; y wraps at IMG_HEIGHT-1.
- Stage 2 (accumulate on valid_r):
  - If pixel_r is nonzero: x_min = min, x_max = max, y_min = min, y_max = max; set found_acc.
  - Empty values: x_min = IMG_WIDTH-1, x_max = 0, y_min = IMG_HEIGHT-1, y_max = 0, found_acc = 0.
- End of frame:
  - The valid_r pixel at (IMG_WIDTH-1, IMG_HEIGHT-1) sets eof.
  - On the following cycle, outputs load from the accumulators, including that last pixel's contribution.
  - bbox_valid pulses for 1 cycle; accumulators return to empty in the same cycle.
  - Latency: bbox_valid is high 3 cycles after the last pixel is presented on pixel_in.
- Empty frame: bbox_found = 0 and all four coordinates are driven 0, not the empty values.
- Outputs hold between pulses; bbox_* change only when bbox_valid is high.
- Back-to-back frames: a valid pixel arriving the cycle after eof is accumulated into the new, just-cleared accumulators and is not lost. Clear and first-pixel update merge; the new pixel wins.
- Gaps: pixel_in_valid low is allowed anywhere; counters and accumulators hold.
- frame_reset:
  - Takes priority over a pixel in the same cycle; that pixel is dropped from the bbox but still forwarded on pixel_out.
  - Clears counters, accumulators, the stage-1 position and any pending eof; no bbox_valid results.
- rst mid-frame: everything returns to the reset values; the partial frame is discarded.

Optional Feature:
- Macro: HW_ACCEL_BBOX_PIXEL_COUNT_EN.
- Defined:
  - Adds output bbox_pixel_count, width $clog2(IMG_WIDTH*IMG_HEIGHT+1), counting foreground pixels in the frame.
  - The count is latched with the box on bbox_valid, saturates at its max, and is reset to 0 by rst/frame_reset/eof.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared hw_accel constants include file:
  - Width derivation (count-bit widths from IMG_WIDTH/IMG_HEIGHT).
  - Foreground test (pixel != 0).
  - Binary levels (all-zeros / all-ones).
- Sub-module hw_accel_xy_counter:
  - Valid-qualified raster x/y counter with wrap, sync clear and eof flag.
  - Reusable by the dilation/erosion stages.

Test Plan (IMG_WIDTH=10, IMG_HEIGHT=4):
- Single foreground pixel at (3,2), rest 0 -> bbox_valid once; found=1; x_min=x_max=3; y_min=y_max=2; pixel_out equals pixel_in one cycle later.
- Foreground at (1,0), (8,1), (4,3) -> x 1..8, y 0..3, found=1; bbox_valid 3 cycles after pixel (9,3) is presented.
- All-zero frame -> found=0, all coordinates 0; next frame with only pixel (9,3) set -> x 9..9, y 3..3.
- Two back-to-back frames without a gap: frame A (0,0) only, frame B (5,1) only -> two pulses, A=(0,0,0,0) and B=(5,5,1,1); no cross-contamination.
- Random valid gaps (~50% duty) on the frame of scenario 2 -> identical results to the gapless run.
- frame_reset asserted after 15 pixels of a frame with foreground at (2,0) and (2,1), then a full frame with only (7,2) -> no pulse for the aborted frame; one pulse x 7..7, y 2..2.
  - Repeat with rst instead of frame_reset -> outputs read 0 during reset, same final result.
